ex_mem_pipe_reg: RTL

Parametrised EX/MEM pipeline register with a valid/ready handshake, an optional skid entry, synchronous flush and a stall-cycle counter. It sits between the execute stage (ALU, branch adder) and the memory stage. It replaces the free-running EX/MEM latch wherever the memory stage can back-pressure, for example on a data-cache miss. Control fields are forced to zero whenever no valid beat is held, so a bubble never writes memory or the register file.

---
 rtl/ex_mem_pipe_reg.sv | 110 +++++++++++
 1 files changed

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: valid/ready handshake, optional skid
// entry, synchronous flush and a saturating stall-cycle counter.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int M_W    = 3,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wb_ctl_in,
  input  logic [M_W-1:0]    m_ctl_in,
  input  logic [DATA_W-1:0] add_result_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] read_data2_in,
  input  logic [REG_W-1:0]  mux_out_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_ctl_out,
  output logic [M_W-1:0]    m_ctl_out,
  output logic [DATA_W-1:0] add_result_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] read_data2_out,
  output logic [REG_W-1:0]  mux_out_out,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [DATA_W-1:0] add;
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rd2;
    logic [REG_W-1:0]  rd;
  } beat_t;

  localparam bit HAS_SKID = (SKID != 0);

  beat_t            main_q;
  beat_t            skid_q;
  beat_t            in_beat;
  logic             main_v;
  logic             skid_v;
  logic             take;
  logic             drain;
  logic [CNT_W-1:0] stall_q;

  assign in_beat = {wb_ctl_in, m_ctl_in, add_result_in, zero_in,
                    alu_result_in, read_data2_in, mux_out_in};

  // with a skid entry, in_ready comes straight from a flop
  assign in_ready = HAS_SKID ? !skid_v : (!main_v || out_ready);
  assign take     = in_valid && in_ready;
  assign drain    = main_v && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (skid_v && drain) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else if (take && (!main_v || drain)) begin
        main_q <= in_beat;
        main_v <= 1'b1;
      end else if (take && HAS_SKID) begin
        skid_q <= in_beat;
        skid_v <= 1'b1;
      end else if (drain) begin
        main_v <= 1'b0;
      end
      if (flush) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (main_v && !out_ready && stall_q != '1) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  // bubbles carry zero control so MEM/WB never act on them
  assign out_valid      = main_v;
  assign wb_ctl_out     = main_v ? main_q.wb : '0;
  assign m_ctl_out      = main_v ? main_q.m : '0;
  assign add_result_out = main_q.add;
  assign zero_out       = main_q.zero;
  assign alu_result_out = main_q.alu;
  assign read_data2_out = main_q.rd2;
  assign mux_out_out    = main_q.rd;
  assign stall_cycles   = stall_q;

endmodule
